// File: rtl/dvi_encoder.sv
// -----------------------------------------------------------------------------
// dvi_encoder
//   DVI 1.0 TMDS encoder for a parallel VGA pixel stream. Each pixel clock
//   produces three 10-bit TMDS characters for a downstream 10:1 serializer:
//   transition-minimized data encoding with DC balancing during active video,
//   and control tokens during blanking.
//
//   Two register stages per lane give a fixed 2-cycle latency for both data
//   and control. There is no handshake and no stall.
//
//   Parameters
//     SYNC_INV   1 = invert VGA_HS/VGA_VS before they become C0/C1 of lane 0
//
//   Ports
//     CLK                  pixel clock (pattern circuit's PCK)
//     RST                  asynchronous reset, active low
//     VGA_R/G/B [7:0]      pixel; R -> lane 2, G -> lane 1, B -> lane 0
//     VGA_HS, VGA_VS       syncs; C0/C1 of lane 0
//     VGA_DE               1 = active pixel, 0 = blanking
//     TMDS_D0/1/2 [9:0]    lane characters, bit 0 transmitted first
//     DISP0/1/2 [5:0]      (DVI_ENC_DISP_MON_EN only) post-update running
//                          disparity of each lane, two's complement, aligned
//                          with the matching TMDS_Dn
//
//   Build option
//     DVI_ENC_DISP_MON_EN  adds the DISPn debug outputs; encoding unchanged.
// -----------------------------------------------------------------------------

// One TMDS lane: stage 1 forms q_m, stage 2 balances disparity / emits tokens.
module dvi_tmds_lane (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] pix,
    input  logic       de,
    input  logic [1:0] ctl,
    output logic [9:0] tmds
`ifdef DVI_ENC_DISP_MON_EN
    ,
    output logic [5:0] disp
`endif
);

    typedef struct packed {
        logic [8:0] q_m;
        logic [3:0] n1;     // ones in q_m[7:0]
        logic       de;
        logic [1:0] ctl;
    } s1_t;

    s1_t        s1_d, s1_q;
    logic [3:0] n1_pix;
    logic       use_xnor;

    logic [9:0] tmds_d, tmds_q;
    logic [5:0] cnt_d, cnt_q;
    logic [5:0] diff;       // N1 - N0 over q_m[7:0]
    logic [5:0] two_q8, two_nq8;
    logic [7:0] qm;
    logic       qm8;

    // ---------------- stage 1: transition minimization ----------------------
    always_comb begin
        n1_pix = '0;
        for (int i = 0; i < 8; i++) n1_pix = n1_pix + {3'b000, pix[i]};
        use_xnor = (n1_pix > 4'd4) || (n1_pix == 4'd4 && !pix[0]);

        s1_d = '0;
        s1_d.q_m[0] = pix[0];
        for (int i = 1; i < 8; i++)
            s1_d.q_m[i] = use_xnor ? ~(s1_d.q_m[i-1] ^ pix[i]) : (s1_d.q_m[i-1] ^ pix[i]);
        s1_d.q_m[8] = ~use_xnor;
        for (int i = 0; i < 8; i++) s1_d.n1 = s1_d.n1 + {3'b000, s1_d.q_m[i]};
        s1_d.de  = de;
        s1_d.ctl = ctl;
    end

    // ---------------- stage 2: DC balance / control tokens ------------------
    always_comb begin
        qm      = s1_q.q_m[7:0];
        qm8     = s1_q.q_m[8];
        diff    = {1'b0, s1_q.n1, 1'b0} - 6'd8;   // 2*N1 - 8 == N1 - N0
        two_q8  = {4'b0000,  qm8, 1'b0};
        two_nq8 = {4'b0000, ~qm8, 1'b0};
        tmds_d  = tmds_q;
        cnt_d   = cnt_q;

        if (!s1_q.de) begin
            // Blanking restarts the balance so every line begins neutral.
            cnt_d = '0;
            case (s1_q.ctl)
                2'b00:   tmds_d = 10'b1101010100;
                2'b01:   tmds_d = 10'b0010101011;
                2'b10:   tmds_d = 10'b0101010100;
                default: tmds_d = 10'b1010101011;
            endcase
        end else if (cnt_q == 6'd0 || diff == 6'd0) begin
            tmds_d = {~qm8, qm8, qm8 ? qm : ~qm};
            cnt_d  = qm8 ? (cnt_q + diff) : (cnt_q - diff);
        end else if (cnt_q[5] == diff[5]) begin
            // Both non-zero with equal sign: the word would worsen the
            // running bias, so send it inverted.
            tmds_d = {1'b1, qm8, ~qm};
            cnt_d  = cnt_q + two_q8 - diff;
        end else begin
            tmds_d = {1'b0, qm8, qm};
            cnt_d  = cnt_q - two_nq8 + diff;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q   <= '0;
            cnt_q  <= '0;
            tmds_q <= 10'h354;
        end else begin
            s1_q   <= s1_d;
            cnt_q  <= cnt_d;
            tmds_q <= tmds_d;
        end
    end

    assign tmds = tmds_q;
`ifdef DVI_ENC_DISP_MON_EN
    assign disp = cnt_q;
`endif

endmodule

module dvi_encoder #(
    parameter bit SYNC_INV = 1'b0
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [7:0] VGA_R,
    input  logic [7:0] VGA_G,
    input  logic [7:0] VGA_B,
    input  logic       VGA_HS,
    input  logic       VGA_VS,
    input  logic       VGA_DE,
    output logic [9:0] TMDS_D0,
    output logic [9:0] TMDS_D1,
    output logic [9:0] TMDS_D2
`ifdef DVI_ENC_DISP_MON_EN
    ,
    output logic [5:0] DISP0,
    output logic [5:0] DISP1,
    output logic [5:0] DISP2
`endif
);

    localparam int NUM_LANES = 3;

    logic                        hs_s, vs_s;
    logic [NUM_LANES-1:0][7:0]   pix;
    logic [NUM_LANES-1:0][1:0]   ctl;
    logic [NUM_LANES-1:0][9:0]   tmds;
`ifdef DVI_ENC_DISP_MON_EN
    logic [NUM_LANES-1:0][5:0]   disp;
`endif

    assign hs_s = VGA_HS ^ SYNC_INV;
    assign vs_s = VGA_VS ^ SYNC_INV;
    assign pix  = {VGA_R, VGA_G, VGA_B};
    // Only lane 0 carries syncs; lanes 1/2 always send the C1C0=00 token.
    assign ctl  = {2'b00, 2'b00, vs_s, hs_s};

    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        dvi_tmds_lane u_lane (
            .clk   (CLK),
            .rst_n (RST),
            .pix   (pix[l]),
            .de    (VGA_DE),
            .ctl   (ctl[l]),
            .tmds  (tmds[l])
`ifdef DVI_ENC_DISP_MON_EN
            ,
            .disp  (disp[l])
`endif
        );
    end

    assign TMDS_D0 = tmds[0];
    assign TMDS_D1 = tmds[1];
    assign TMDS_D2 = tmds[2];
`ifdef DVI_ENC_DISP_MON_EN
    assign DISP0 = disp[0];
    assign DISP1 = disp[1];
    assign DISP2 = disp[2];
`endif

endmodule

// File: doc/dvi_encoder.md
Name: dvi_encoder

Overview:
- Consumes the pattern circuit's parallel VGA pixel stream (VGA_R/G/B, VGA_HS, VGA_VS, VGA_DE, clocked by PCK).
- Produces three 10-bit TMDS characters per pixel clock, for the downstream 10:1 serializer that drives the Cora Z7 HDMI/DVI output.
- Implements DVI 1.0 TMDS encoding: minimized-transition data encoding, DC-balancing, and control-token insertion during blanking.

Parameters:
- SYNC_INV, 0, 1 = invert VGA_HS and VGA_VS before they are encoded as C0/C1 on channel 0.

Ports:
- CLK  in  1  pixel clock; connected to the pattern circuit's PCK.
- RST  in  1  asynchronous, active-low reset.
- VGA_R  in  8  red pixel; encoded on channel 2.
- VGA_G  in  8  green pixel; encoded on channel 1.
- VGA_B  in  8  blue pixel; encoded on channel 0.
- VGA_HS  in  1  horizontal sync; C0 of channel 0.
- VGA_VS  in  1  vertical sync; C1 of channel 0.
- VGA_DE  in  1  data enable; 1 = active pixel.
- TMDS_D0  out  10  channel 0 character; bit 0 is transmitted first.
- TMDS_D1  out  10  channel 1 character.
- TMDS_D2  out  10  channel 2 character.

Behaviour:
- Reset (RST=0): TMDS_D0/1/2 = 10'h354 (control token C1C0=00) immediately; all pipeline registers and disparity counters clear to 0.
- Fixed latency of 2 CLK cycles from input sample to output character, for both data and control. There is no stall and no handshake; one character is produced per cycle per channel.
- Stage 1, per channel, on pixel byte D:
  - N1(D) = number of ones in D.
  - If N1>4, or N1==4 with D[0]==0: XNOR chain. q_m[0]=D[0]; q_m[i]=q_m[i-1] XNOR D[i]; q_m[8]=0.
  - Otherwise: XOR chain, q_m[8]=1.
  - Register q_m, N1(q_m[7:0]), DE, HS and VS (after SYNC_INV).
- Stage 2, per channel, with running disparity cnt (6-bit signed, two's complement):
  - DE=0: output the control token and set cnt=0. Channel 0 uses C1C0={VS,HS}; channels 1 and 2 use C1C0=00.
    - 00 -> 10'b1101010100
    - 01 -> 10'b0010101011
    - 10 -> 10'b0101010100
    - 11 -> 10'b1010101011
  - DE=1, cnt==0 or N1==N0 (counts taken over q_m[7:0]):
    - out = {~q_m[8], q_m[8], q_m[8] ? q_m[7:0] : ~q_m[7:0]}.
    - cnt += q_m[8] ? (N1-N0) : (N0-N1).
  - DE=1, (cnt>0 and N1>N0) or (cnt<0 and N0>N1):
    - out = {1, q_m[8], ~q_m[7:0]}.
    - cnt += 2*q_m[8] + (N0-N1).
  - DE=1, all other cases:
    - out = {0, q_m[8], q_m[7:0]}.
    - cnt += -2*(~q_m[8]) + (N1-N0).
- Boundary conditions:
  - cnt is bounded to -10..+10 by the algorithm; no saturation logic is required.
  - DE falling: the first blanking cycle outputs a token and zeroes cnt.
  - DE rising: the first active pixel starts with cnt=0.
  - Reset asserted mid-line: outputs go to 10'h354 asynchronously.
  - Reset release: the first encoded character appears at the second rising CLK edge after release.

Optional Feature:
- Macro DVI_ENC_DISP_MON_EN.
- Defined: adds output ports DISP0, DISP1 and DISP2 (6-bit signed each) carrying each channel's post-update cnt, aligned with its TMDS_Dn, for debug and bench checking.
- Undefined: these ports and their logic are absent; encoding behaviour is identical in both cases.

Test Plan:
- Reset: hold RST=0 with random inputs -> all TMDS_Dn = 10'h354. Release, then DE=0, HS=0, VS=0 -> 10'h354 after 2 cycles.
- Control tokens: DE=0, {VS,HS} = 01 / 10 / 11 -> TMDS_D0 = 10'h0AB / 10'h154 / 10'h2AB at 2-cycle latency; TMDS_D1 and TMDS_D2 = 10'h354.
- Blue pixel sequence: DE=1, B=8'h00 then 8'h00 -> TMDS_D0 = 10'h100 (cnt -8), then 10'h3FF (cnt +2). Separately, from cnt 0, B=8'hFF -> 10'h200 (cnt -8).
- Disparity reset on blanking: B=8'h00, one cycle of DE=0, then B=8'h00 -> TMDS_D0 = 10'h100, 10'h354, 10'h100.
- Round trip: full 640x480 frame from the pattern circuit plus 10k random pixels -> a bench TMDS decoder recovers RGB/HS/VS exactly at 2-cycle latency; |cnt| <= 10 throughout; DISPn matches the model when DVI_ENC_DISP_MON_EN is defined.
- SYNC_INV=1 and async reset: HS=1, VS=0 in blanking -> TMDS_D0 = 10'h154. Asserting RST mid-active-line -> 10'h354 with no CLK edge required.
